ram_cmd_responder: RTL and testbench
====================================

Name: ram_cmd_responder

Overview:
- Responder end of the CPU-to-RAM command interface.
- Accepts IDLE/GET/SET/RESET commands on `operation`, services them on a register-file word array, and answers on `data_out`/`done` with a strict four-phase handshake.
- Sits between the mini-CPU control FSM and storage. It replaces ad-hoc memory handling so that `done` semantics are defined exactly.

Parameters:
- ADDR_W, 4, address width.
- DATA_W, 16, word width.
- DEPTH, 2**ADDR_W, number of words (16).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- operation  input  2  command: 0 IDLE, 1 GET, 2 SET, 3 RESET.
- address  input  ADDR_W  word address for GET/SET.
- data_in  input  DATA_W  write data for SET.
- data_out  output  DATA_W  read data, registered.
- done  output  1  command complete; held until `operation` returns to IDLE.
- busy  output  1  high from command acceptance until return to S_IDLE.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=S_IDLE, data_out=0, done=0, busy=0, clear counter=0.
  - All DEPTH words = 0.
- FSM states: S_IDLE, S_READ, S_WRITE, S_CLEAR, S_DONE.
- S_IDLE:
  - operation==IDLE: stay.
  - Otherwise latch op, address and data_in, set busy=1, and go to S_READ / S_WRITE / S_CLEAR for GET / SET / RESET.
  - Port changes after the acceptance edge are ignored for that command.
- S_READ: data_out <= mem[addr_latched]; done<=1; go S_DONE. GET latency: done and valid data_out visible 2 clocks after the edge where operation first seen non-IDLE.
- S_WRITE: mem[addr_latched] <= data_latched; data_out unchanged; done<=1; go S_DONE. Same 2-clock latency.
- S_CLEAR:
  - Writes 0 to mem[clr_cnt] and increments clr_cnt, one word per clock.
  - At clr_cnt==DEPTH-1: write the word, reset clr_cnt to 0, data_out<=0, done<=1, go S_DONE.
  - RESET latency: DEPTH+1 clocks to done (17 at defaults).
- S_DONE:
  - done=1, busy=1 while operation != IDLE, including when the master switches directly to a different non-IDLE command; that command is NOT accepted.
  - When operation==IDLE: done<=0, busy<=0, go S_IDLE. done therefore falls 1 clock after IDLE is presented.
  - A new command is accepted no earlier than the clock after returning to S_IDLE.
- data_out holds its last value in all states except S_READ and RESET completion. Only GET and RESET completion update it.
- GET immediately after SET to the same address returns the new value; there is no bypass hazard, since the write completes before the GET is accepted.
- Address arithmetic is unsigned. clr_cnt is ADDR_W bits and wraps naturally.
- reset_n asserted mid-command (any state): immediate return to reset values. A partial clear is abandoned and the whole array is zeroed anyway.
- Undefined operation values are impossible (2-bit, all decoded).

Optional Feature:
- Macro RAM_VALID_MASK_EN.
- Defined:
  - Adds output `valid` [DEPTH-1:0]. Bit i is set on SET to address i, cleared by RESET command and by reset_n.
  - GET of an address whose valid bit is 0 returns data_out=0 regardless of array contents.
- Undefined: no `valid` port; GET always returns the stored word.

Test Plan:
- Post-reset GET: reset_n low 3 clocks, release; GET addr 5 -> done high 2 clocks after acceptance, data_out=0x0000; drop to IDLE -> done low next clock.
- SET/GET round trip: SET addr 3 data 0x007F, handshake, then GET addr 3 -> data_out=0x007F. GET addr 4 -> 0x0000.
- Four-phase enforcement: after SET done, hold operation=SET with new data 0x1234 for 5 clocks -> done stays 1, mem[3] stays 0x007F, busy=1 throughout.
- RESET sweep: fill addrs 0..15 with 0x00A0+i; issue RESET -> done exactly 17 clocks after acceptance, data_out=0. GET each address -> 0x0000.
- Mid-operation reset: start RESET, pull reset_n low at clear cycle 6 -> done=0, busy=0, data_out=0 immediately; after release, GET addr 15 -> 0x0000 and a new command is accepted normally.
- RAM_VALID_MASK_EN:
  - SET addr 7 = 0x0011 -> valid=0x0080. GET addr 7 -> 0x0011; GET addr 2 -> 0x0000.
  - RESET -> valid=0x0000.

Source files
------------

// File: rtl/ram_cmd_responder.sv
// ram_cmd_responder: four-phase GET/SET/RESET responder over a DEPTH-word register file.
// Optional macro RAM_VALID_MASK_EN adds a per-word valid mask; GET of an invalid word returns 0.
module ram_cmd_responder #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        operation,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              busy
`ifdef RAM_VALID_MASK_EN
    ,
    output logic [DEPTH-1:0]  valid
`endif
);
    localparam logic [1:0] OP_IDLE = 2'd0;
    localparam logic [1:0] OP_GET  = 2'd1;
    localparam logic [1:0] OP_SET  = 2'd2;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_CLEAR, S_DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;

    // Read mux: with the valid mask, never-written words read as zero
`ifdef RAM_VALID_MASK_EN
    always_comb rd_word = valid[addr_q] ? mem[addr_q] : '0;
`else
    always_comb rd_word = mem[addr_q];
`endif

    // Command sequencer: accept in S_IDLE, service, then hold done until the master returns to IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            clr_cnt  <= '0;
            data_out <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            mem      <= '{default: '0};
`ifdef RAM_VALID_MASK_EN
            valid    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (operation != OP_IDLE) begin
                        addr_q <= address;
                        data_q <= data_in;
                        busy   <= 1'b1;
                        state  <= (operation == OP_GET) ? S_READ :
                                  (operation == OP_SET) ? S_WRITE : S_CLEAR;
                    end
                end
                S_READ: begin
                    data_out <= rd_word;
                    done     <= 1'b1;
                    state    <= S_DONE;
                end
                S_WRITE: begin
                    mem[addr_q] <= data_q;
`ifdef RAM_VALID_MASK_EN
                    valid[addr_q] <= 1'b1;
`endif
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_CLEAR: begin
                    mem[clr_cnt] <= '0;
                    clr_cnt      <= clr_cnt + 1'b1;
                    if (clr_cnt == CLR_LAST) begin
                        clr_cnt  <= '0;
                        data_out <= '0;
                        done     <= 1'b1;
                        state    <= S_DONE;
`ifdef RAM_VALID_MASK_EN
                        valid    <= '0;
`endif
                    end
                end
                S_DONE: begin
                    if (operation == OP_IDLE) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_cmd_responder.sv
// tb_ram_cmd_responder: directed scoreboard bench for ram_cmd_responder (honours RAM_VALID_MASK_EN).
`timescale 1ns/1ps
module tb_ram_cmd_responder;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GET  = 2'd1;
    localparam logic [1:0] SET  = 2'd2;
    localparam logic [1:0] RST  = 2'd3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  operation = IDLE;
    logic [3:0]  address = '0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        done;
    logic        busy;
`ifdef RAM_VALID_MASK_EN
    logic [15:0] valid;
    logic [15:0] valid_m = '0;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] mem_m [16];
    logic [15:0] last_d = '0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    ram_cmd_responder dut (
        .clk(clk),
        .reset_n(reset_n),
        .operation(operation),
        .address(address),
        .data_in(data_in),
        .data_out(data_out),
        .done(done),
        .busy(busy)
`ifdef RAM_VALID_MASK_EN
        ,
        .valid(valid)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mem_m[i] = '0;
        last_d = '0;
`ifdef RAM_VALID_MASK_EN
        valid_m = '0;
`endif
    endtask

    // Issue one command, check its latency, optionally hold it (switching command midway), then release.
    task automatic cmd(input logic [1:0] op, input logic [3:0] a, input logic [15:0] d,
                       input int lat, input int hold);
        int n;
        logic [15:0] e;
        n = 0;
        if (op == GET) begin
            e = mem_m[a];
`ifdef RAM_VALID_MASK_EN
            if (!valid_m[a]) e = '0;
`endif
            last_d = e;
        end else if (op == SET) begin
            mem_m[a] = d;
`ifdef RAM_VALID_MASK_EN
            valid_m[a] = 1'b1;
`endif
            e = last_d;
        end else begin
            model_clear();
            e = '0;
        end
        exp_q.push_back(e);
        @(negedge clk);
        operation = op;
        address = a;
        data_in = d;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                chk("accept_busy", busy, 1);
                address = ~a;
                data_in = ~d;
            end
        end while (!done && n < 40);
        chk("latency", n, lat);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            data_in = 16'h1234;
            if (k >= 2) operation = (op == GET) ? SET : GET;
            @(posedge clk);
            #1;
            chk("hold_done", done, 1);
            chk("hold_busy", busy, 1);
        end
        @(negedge clk);
        operation = IDLE;
        @(posedge clk);
        #1;
        chk("done_fall", done, 0);
        chk("busy_fall", busy, 0);
    endtask

    // Monitor: each rising done pops one expected data_out
    initial begin
        logic prev;
        logic [15:0] e;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (done && !prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got data_out 0x%0h, expected no response", data_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_out", data_out, e);
                end
            end
            prev = done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", data_out, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;

        cmd(GET, 4'd5, 16'h0000, 2, 0);

`ifdef RAM_VALID_MASK_EN
        cmd(SET, 4'd7, 16'h0011, 2, 0);
        chk("valid_after_set", valid, 16'h0080);
        cmd(GET, 4'd7, 16'h0000, 2, 0);
        cmd(GET, 4'd2, 16'h0000, 2, 0);
        cmd(RST, 4'd0, 16'h0000, 17, 0);
        chk("valid_after_reset", valid, 16'h0000);
`endif

        cmd(SET, 4'd3, 16'h007F, 2, 5);
        cmd(GET, 4'd3, 16'h0000, 2, 0);
        cmd(GET, 4'd4, 16'h0000, 2, 0);
        cmd(GET, 4'd3, 16'h0000, 2, 4);

        for (int i = 0; i < 16; i++) cmd(SET, 4'(i), 16'h00A0 + 16'(i), 2, 0);
        cmd(GET, 4'd9, 16'h0000, 2, 0);
        cmd(RST, 4'd0, 16'h0000, 17, 0);
        for (int i = 0; i < 16; i++) cmd(GET, 4'(i), 16'h0000, 2, 0);

        cmd(SET, 4'd15, 16'hBEEF, 2, 0);
        cmd(GET, 4'd15, 16'h0000, 2, 0);
        @(negedge clk);
        operation = RST;
        repeat (7) @(posedge clk);
        #1;
        chk("mid_clear_busy", busy, 1);
        chk("mid_clear_done", done, 0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_done", done, 0);
        chk("async_busy", busy, 0);
        chk("async_data_out", data_out, 0);
        model_clear();
        operation = IDLE;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cmd(GET, 4'd15, 16'h0000, 2, 0);
        cmd(SET, 4'd1, 16'hCAFE, 2, 0);
        cmd(GET, 4'd1, 16'h0000, 2, 0);

        repeat (3) @(posedge clk);
        #3;
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
